single_vector_collect: RTL
==========================

// Module: single_vector_collect
// PURPOSE
//  Deserializer feeding the vector datapath: accepts single-precision words one per
//  valid/ready beat, packs them into a WIDTH-lane vector, presents it with out_valid.
//  Vector-side counterpart of the parallel reduction trees; zero-fills unused lanes
//  so short frames (in_last) sum correctly downstream.
// PARAMETERS
//  WIDTH   10  number of 32-bit lanes in out_vector (>=2)
// PORTS
//  clk         in   1          clock; all logic on rising edge
//  rst         in   1          reset: synchronous, active-high
//  in_valid    in   1          in_data/in_last valid
//  in_ready    out  1          block can accept a word this cycle
//  in_data     in   32         IEEE-754 single word
//  in_last     in   1          final word of frame (qualified by in_valid&in_ready)
//  out_valid   out  1          out_vector/out_count valid; held until out_ready
//  out_ready   in   1          downstream accepts vector
//  out_vector  out  32xWIDTH   unpacked array [WIDTH], lane 0 = first word of frame
//  out_count   out  CW         lanes written this frame, 1..WIDTH; CW=$clog2(WIDTH+1)
//  out_nan     out  1          only with SINGLE_COLLECT_NAN_CHECK_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=FILL, cnt=0, all lanes=32'h0, out_valid=0,
//    out_count=0, out_nan=0; in_ready=1 first cycle after reset. Partial frame discarded.
//  - States: FILL (in_ready=1, out_valid=0), FULL (in_ready=0, out_valid=1).
//  - FILL, accept (in_valid&in_ready): lane[cnt]<=in_data; cnt++.
//    If cnt==WIDTH-1 or in_last: ->FULL, out_count<=cnt+1, cnt<=0.
//    in_last on lane WIDTH-1 is the same as a full frame.
//  - Latency: last word accepted at edge N -> out_valid=1 after edge N.
//  - FULL: out_vector/out_count/out_nan stable. in_valid ignored (no accept, no
//    state change). On out_valid&out_ready: ->FILL, all lanes<=0, out_count<=0,
//    out_nan<=0; in_ready=1 next cycle. No same-cycle bypass: one frame = count+1
//    cycles min.
//  - Unwritten lanes of short frame are exactly 32'h0 (+0.0).
//  - in_valid with in_ready=0: word not consumed; source must hold it (AXI-style).
//  - Data passed bit-exact; no float arithmetic, NaN/denormal untouched.
//  - cnt never exceeds WIDTH-1; no wrap inside a frame.
// CONFIGURATION
//  SINGLE_COLLECT_NAN_CHECK_EN defined: out_nan port exists; sticky flag set on any
//   accepted word with exp==8'hFF and mantissa!=0; valid with out_valid, cleared at
//   output handshake and reset. Infinity does not set it.
//  Undefined: out_nan port and flag logic absent; all else identical.
// STRUCTURE
//  single_pkg: typedef logic [31:0] single_t; localparam single_t SINGLE_ZERO=32'h0;
//   function is_nan(single_t). Shared with sum/add blocks.
//  State enum local to module (2 states). No sub-module; single flat module.
// TESTING
//  1 rst held 3 cycles, then released -> in_ready=1, out_valid=0, lanes all 0.
//  2 WIDTH=10, feed 1.0..10.0 (3F800000..41200000) back-to-back, out_ready=1 ->
//    out_valid one cycle after 10th accept, out_count=10, lanes in order.
//  3 feed 3 words 40000000,40400000,40800000 with in_last on 3rd ->
//    out_count=3, lanes 3..9 = 0; feed to single_sum_v -> c=41100000 (9.0).
//  4 out_ready=0 for 5 cycles in FULL while in_valid=1 -> in_ready=0, vector
//    stable, no words lost; release -> next frame starts at lane 0.
//  5 rst asserted after 4 accepts -> out_valid stays 0, next frame lane 0 = next word.
//  6 (NAN_CHECK_EN) word 7FC00000 in frame -> out_nan=1 with out_valid; 7F800000 -> 0.

Source files
------------

// File: rtl/single_pkg.sv
// ----------------------------------------------------------------------------
// single_pkg
// Shared definitions for the single-precision vector blocks (collect, sum,
// add). Provides the raw IEEE-754 word type, the +0.0 constant and a NaN
// classifier. No arithmetic here: words are handled bit-exact.
// ----------------------------------------------------------------------------
package single_pkg;

    typedef logic [31:0] single_t;

    localparam single_t SINGLE_ZERO = 32'h0000_0000;

    // Exponent all ones with a non-zero mantissa. Infinity (mantissa zero) is
    // not a NaN.
    function automatic logic is_nan(input single_t w);
        return (w[30:23] == 8'hFF) && (w[22:0] != 23'h0);
    endfunction

endpackage

// File: rtl/single_vector_collect.sv
// ----------------------------------------------------------------------------
// single_vector_collect
// Deserializer in front of the vector datapath. Single-precision words arrive
// one per valid/ready beat and are packed into a WIDTH-lane vector, lane 0
// holding the first word of the frame. A frame closes when WIDTH words have
// been taken or when in_last is seen; lanes not written by a short frame stay
// +0.0 so a downstream reduction sums them correctly.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_valid    in_data/in_last valid
//   in_ready    block can accept a word this cycle (FILL state)
//   in_data     IEEE-754 single word, passed through bit-exact
//   in_last     final word of the frame
//   out_valid   out_vector/out_count valid, held until out_ready
//   out_ready   downstream accepts the vector
//   out_vector  WIDTH lanes, lane 0 = first word of the frame
//   out_count   lanes written this frame (1..WIDTH), 0 while not valid
//   out_nan     sticky "frame contained a NaN" flag, valid with out_valid
//
// Build option
//   SINGLE_COLLECT_NAN_CHECK_EN  when defined, adds out_nan and its flag logic.
// ----------------------------------------------------------------------------
module single_vector_collect
    import single_pkg::*;
#(
    parameter  int WIDTH = 10,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  single_t       in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output single_t       out_vector [WIDTH],
    output logic [CW-1:0] out_count
`ifdef SINGLE_COLLECT_NAN_CHECK_EN
    ,
    output logic          out_nan
`endif
);

    // Lane index width; cnt never exceeds WIDTH-1.
    localparam int IW = $clog2(WIDTH);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   cnt;
    logic [CW-1:0]   count_q;
    single_t         lanes [WIDTH];

    logic            accept;
    logic            frame_done;
    logic            out_hs;

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        frame_done = 1'b0;
        out_hs     = 1'b0;
        case (state)
            FILL: begin
                in_ready   = 1'b1;
                accept     = in_valid;
                // in_last on the final lane closes the frame exactly like a
                // naturally full one.
                frame_done = in_valid && ((cnt == IW'(WIDTH - 1)) || in_last);
                if (frame_done) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                // Incoming words are left on the bus untouched while we hold
                // the vector; the source keeps them until in_ready returns.
                out_valid = 1'b1;
                out_hs    = out_ready;
                if (out_ready) begin
                    state_nxt = FILL;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            cnt     <= '0;
            count_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                lanes[i] <= SINGLE_ZERO;
            end
        end else begin
            state <= state_nxt;

            if (accept) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (cnt == IW'(i)) begin
                        lanes[i] <= in_data;
                    end
                end
                if (frame_done) begin
                    cnt     <= '0;
                    count_q <= CW'(cnt) + CW'(1);
                end else begin
                    cnt <= cnt + IW'(1);
                end
            end

            // Clearing on handshake is what guarantees zero-filled tails for
            // the next short frame.
            if (out_hs) begin
                count_q <= '0;
                for (int i = 0; i < WIDTH; i++) begin
                    lanes[i] <= SINGLE_ZERO;
                end
            end
        end
    end

    assign out_vector = lanes;
    assign out_count  = count_q;

`ifdef SINGLE_COLLECT_NAN_CHECK_EN
    logic nan_q;

    // Sticky across the frame; accept and handshake never coincide because
    // they belong to different states.
    always_ff @(posedge clk) begin
        if (rst) begin
            nan_q <= 1'b0;
        end else if (out_hs) begin
            nan_q <= 1'b0;
        end else if (accept && is_nan(in_data)) begin
            nan_q <= 1'b1;
        end
    end

    assign out_nan = nan_q;
`endif

endmodule
